// File: rtl/serdes_tx_pkg.sv
// Shared types and defaults for the serializer TX scheduler and its slot timer.
package serdes_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StData,
    StCksum,
    StPost
  } state_e;

  localparam logic [7:0]  FLAG_BYTE       = 8'h7E;
  localparam int unsigned DEF_PIN_NUM     = 5;
  localparam int unsigned DEF_SLOT_CYCLES = 10;

  // Width of a counter that runs 0..modulus-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus < 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/serdes_tx_scheduler_if.sv
// Upstream word stream (valid/ready) from the TX packet buffer to the scheduler.
interface serdes_tx_scheduler_if
  import serdes_tx_pkg::*;
#(
  parameter int unsigned PIN_NUM = DEF_PIN_NUM
);

  logic [8*PIN_NUM-1:0] s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/serdes_slot_timer.sv
// Free-running symbol slot counter. decision_o marks the last clock of a slot;
// strobe_o is the registered load pulse in the first clock of the next slot.
module serdes_slot_timer
  import serdes_tx_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = DEF_SLOT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  output logic decision_o,
  output logic strobe_o
);

  localparam int unsigned CntW = cnt_width(SLOT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(SLOT_CYCLES - 1);

  logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
  logic            strobe_q, strobe_d;

  // Wrap the slot counter and arm the strobe for the clock after the decision.
  always_comb begin
    slot_cnt_d = (slot_cnt_q == CntMax) ? '0 : slot_cnt_q + CntW'(1);
    strobe_d   = (slot_cnt_q == CntMax);
  end

  // Slot counter and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      strobe_q   <= strobe_d;
    end
  end

  assign decision_o = (slot_cnt_q == CntMax);
  assign strobe_o   = strobe_q;

endmodule

// File: rtl/serdes_tx_scheduler.sv
// Frames upstream packet words into serializer slots with 7E flag preamble,
// closing flags and idle fill. Optional feature macro SERDES_TX_CHECKSUM_EN
// appends a per-lane XOR checksum slot after the last word of each packet.
module serdes_tx_scheduler
  import serdes_tx_pkg::*;
#(
  parameter int unsigned PIN_NUM        = DEF_PIN_NUM,
  parameter int unsigned SLOT_CYCLES    = DEF_SLOT_CYCLES,
  parameter int unsigned PREAMBLE_FLAGS = 2,
  parameter int unsigned GAP_FLAGS      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  serdes_tx_scheduler_if.slave s,
  output logic [8*PIN_NUM-1:0] ser_datin,
  output logic                 ser_start,
  output logic [PIN_NUM-1:0]   ser_flag7E,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 err_underrun
);

  localparam int unsigned PreW = cnt_width(PREAMBLE_FLAGS);
  localparam int unsigned GapW = cnt_width(GAP_FLAGS);
  localparam logic [PreW-1:0] PreLast = PreW'((PREAMBLE_FLAGS == 0) ? 0 : PREAMBLE_FLAGS - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_FLAGS - 1);
  localparam bit NoPreamble = (PREAMBLE_FLAGS == 0);

  typedef logic [8*PIN_NUM-1:0] word_t;

  state_e          state_q, state_d;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic            abort_q, abort_d;
  word_t           datin_q, datin_d;
  logic            flag_q, flag_d;
  logic            done_q, done_d;
  logic            urun_q, urun_d;
`ifdef SERDES_TX_CHECKSUM_EN
  word_t           xor_q, xor_d;
`endif
  logic            decision;
  logic            accept_state;

  serdes_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_slot_timer (
    .clk        (clk),
    .rst        (rst),
    .decision_o (decision),
    .strobe_o   (ser_start)
  );

  // Slots in which a word may be taken; without preamble IDLE accepts directly.
  assign accept_state = (state_q == StData) ||
                        ((state_q == StPre) && (pre_cnt_q == PreLast)) ||
                        (NoPreamble && (state_q == StIdle) && s.s_valid);
  assign s.s_ready    = decision && accept_state;

  // Slot FSM: every transition and slot load happens on a decision cycle only.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    gap_cnt_d = gap_cnt_q;
    abort_d   = abort_q;
    datin_d   = datin_q;
    flag_d    = flag_q;
    done_d    = 1'b0;
    urun_d    = 1'b0;
`ifdef SERDES_TX_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    if (decision) begin
      // Flag unless a data slot is loaded below; datin holds across flags.
      flag_d = 1'b1;
      if (accept_state) begin
        if (s.s_valid) begin
          flag_d  = 1'b0;
          datin_d = s.s_data;
`ifdef SERDES_TX_CHECKSUM_EN
          xor_d   = ((state_q == StIdle) ? '0 : xor_q) ^ s.s_data;
`endif
          if (s.s_last) begin
`ifdef SERDES_TX_CHECKSUM_EN
            state_d = StCksum;
`else
            state_d = StPost;
`endif
            gap_cnt_d = '0;
          end else begin
            state_d = StData;
          end
        end else begin
          // Upstream ran dry mid-packet: abort and close with flags only.
          urun_d    = 1'b1;
          abort_d   = 1'b1;
          state_d   = StPost;
          gap_cnt_d = '0;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (s.s_valid) begin
              state_d   = StPre;
              pre_cnt_d = '0;
              abort_d   = 1'b0;
`ifdef SERDES_TX_CHECKSUM_EN
              xor_d     = '0;
`endif
            end
          end
          StPre: pre_cnt_d = pre_cnt_q + PreW'(1);
`ifdef SERDES_TX_CHECKSUM_EN
          StCksum: begin
            flag_d    = 1'b0;
            datin_d   = xor_q;
            state_d   = StPost;
            gap_cnt_d = '0;
          end
`endif
          StPost: begin
            done_d = (gap_cnt_q == '0) && !abort_q;
            if (gap_cnt_q == GapLast) begin
              state_d = StIdle;
            end else begin
              gap_cnt_d = gap_cnt_q + GapW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State and registered serializer-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pre_cnt_q <= '0;
      gap_cnt_q <= '0;
      abort_q   <= 1'b0;
      datin_q   <= '0;
      flag_q    <= 1'b1;
      done_q    <= 1'b0;
      urun_q    <= 1'b0;
`ifdef SERDES_TX_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      abort_q   <= abort_d;
      datin_q   <= datin_d;
      flag_q    <= flag_d;
      done_q    <= done_d;
      urun_q    <= urun_d;
`ifdef SERDES_TX_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  assign ser_datin    = datin_q;
  assign ser_flag7E   = {PIN_NUM{flag_q}};
  assign busy         = (state_q != StIdle);
  assign pkt_done     = done_q;
  assign err_underrun = urun_q;

endmodule
